// File: rtl/rv_pkg.sv
// Shared constants for the rv fetch front end: widths, reset PC and
// fetch FSM state encoding.
package rv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  localparam logic ST_REQ  = 1'b0;
  localparam logic ST_WAIT = 1'b1;

endpackage

// File: rtl/rv_fetch_fifo.sv
// DEPTH-entry FIFO holding {instr, pc} pairs; flush is synchronous and
// overrides push/pop.
module rv_fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {{(CW-1){1'b0}}, push_i} - {{(CW-1){1'b0}}, pop_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == {CW{1'b0}});

endmodule

// File: rtl/rv_fetch_fifo_chk.sv
// Protocol checker for the fetch queue: a push may never land in a full
// queue unless a pop or flush frees room in the same cycle.
module rv_fetch_fifo_chk (
  input logic clk_i,
  input logic rst_i,
  input logic push_i,
  input logic pop_i,
  input logic flush_i,
  input logic full_i
);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full_i && !pop_i && !flush_i))
    else $error("rv_fetch_fifo: push into full queue");

endmodule

// File: rtl/rv_ifu.sv
// Instruction fetch unit: PC, single-outstanding req/gnt/rvalid fetch FSM,
// redirect kill handling and a small instruction queue toward decode.
module rv_ifu
  import rv_pkg::*;
#(
  parameter int               XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(rv_pkg::RESET_PC_DEFAULT),
  parameter int               DEPTH    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  output logic             instr_valid_o,
  output logic [31:0]      instr_o,
  output logic [XLEN-1:0]  instr_pc_o,
  input  logic             instr_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = ILEN + XLEN;
  localparam logic [CW-1:0]   CNT_DEPTH  = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic            state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            kill_q, kill_d;

  logic            req_s, push_s, pop_s, valid_s;
  logic [FW-1:0]   head_s;
  logic [CW-1:0]   count_s;
  logic            full_s, empty_s;

  // Space is reserved at request time, so a granted fetch always has a slot.
  assign req_s   = !rst_i && (state_q == ST_REQ) && (count_s < CNT_DEPTH) && !redirect_i;
  assign valid_s = !empty_s && !redirect_i;
  assign pop_s   = valid_s && instr_ready_i;
  assign push_s  = (state_q == ST_WAIT) && imem_rvalid_i && !kill_q && !redirect_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i & ALIGN_MASK;
      if (state_q == ST_WAIT) begin
        // A same-cycle response is simply dropped; otherwise remember to drop it.
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
          kill_d  = 1'b0;
        end else begin
          kill_d  = 1'b1;
        end
      end else begin
        state_d = ST_REQ;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (req_s && imem_gnt_i) begin
            fetch_pc_d = pc_q;
            pc_d       = pc_q + PC_STEP;
            state_d    = ST_WAIT;
          end else begin
            state_d    = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid_i) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= {XLEN{1'b0}};
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
    end
  end

  rv_fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (push_s),
    .data_i  ({imem_rdata_i, fetch_pc_q}),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  rv_fetch_fifo_chk u_fifo_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (redirect_i),
    .full_i  (full_s)
  );

  assign imem_req_o    = req_s;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_s;
  assign instr_o       = head_s[FW-1:XLEN];
  assign instr_pc_o    = head_s[XLEN-1:0];

endmodule

// File: tb/tb_rv_ifu.sv
// Directed bench for rv_ifu: a cycle task plays instruction memory and
// records requests and delivered instructions for hand-computed checks.
module tb_rv_ifu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [63:0] instr_pc_o;
  logic        instr_ready_i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] req_log [$];
  logic [63:0] out_pc  [$];
  logic [31:0] out_ins [$];
  int          out_cyc [$];

  logic        pend;
  int          pend_cnt;
  logic [63:0] pend_addr;
  int          gnt_wait, wait_cnt, rv_extra, cyc_no;
  int          req_hi_cnt, addr_bad;
  logic [63:0] hold_addr;
  logic        last_req, last_valid;
  logic [63:0] last_addr;

  always #5 clk_i = ~clk_i;

  rv_ifu dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  function automatic logic [31:0] ins_of(logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock of memory behaviour, entered and left at a negedge.
  task automatic cyc();
    logic granted;
    imem_rvalid_i = pend && (pend_cnt == 0);
    imem_rdata_i  = imem_rvalid_i ? ins_of(pend_addr) : 32'h0;
    #1;
    imem_gnt_i = 1'b0;
    if (imem_req_o) begin
      req_hi_cnt++;
      if (wait_cnt == 0) hold_addr = imem_addr_o;
      else if (imem_addr_o != hold_addr) addr_bad++;
      if (wait_cnt >= gnt_wait) imem_gnt_i = 1'b1;
      else wait_cnt++;
    end
    #1;
    last_req   = imem_req_o;
    last_valid = instr_valid_o;
    last_addr  = imem_addr_o;
    granted    = imem_req_o && imem_gnt_i;
    if (instr_valid_o && instr_ready_i) begin
      out_pc.push_back(instr_pc_o);
      out_ins.push_back(instr_o);
      out_cyc.push_back(cyc_no);
    end
    @(posedge clk_i);
    if (imem_rvalid_i) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (granted) begin
      req_log.push_back(last_addr);
      pend      = 1'b1;
      pend_cnt  = rv_extra;
      pend_addr = last_addr;
      wait_cnt  = 0;
    end
    cyc_no++;
    @(negedge clk_i);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    redirect_i = 1'b0; redirect_pc_i = 64'h0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    instr_ready_i = 1'b1;
    pend = 1'b0; pend_cnt = 0; pend_addr = 64'h0;
    gnt_wait = 0; wait_cnt = 0; rv_extra = 0;
    req_hi_cnt = 0; addr_bad = 0; hold_addr = 64'h0;
    req_log.delete(); out_pc.delete(); out_ins.delete(); out_cyc.delete();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    cyc_no = 0;
    rst_i = 1'b1;
    redirect_i = 1'b0; redirect_pc_i = 64'h0; instr_ready_i = 1'b1;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    #1;
    check("rst_req",   64'(imem_req_o),    64'h0);
    check("rst_valid", 64'(instr_valid_o), 64'h0);
    check("rst_instr", 64'(instr_o),       64'h0);
    check("rst_ipc",   instr_pc_o,         64'h0);
    check("rst_addr",  imem_addr_o,        64'h0000_0000_8000_0000);

    // Streaming at peak rate
    reset_dut();
    run(7);
    check("t1_nreq",  64'(req_log.size()), 64'd4);
    check("t1_req0",  req_log[0], 64'h0000_0000_8000_0000);
    check("t1_req1",  req_log[1], 64'h0000_0000_8000_0004);
    check("t1_req2",  req_log[2], 64'h0000_0000_8000_0008);
    check("t1_nout",  64'(out_pc.size()), 64'd3);
    check("t1_pc0",   out_pc[0], 64'h0000_0000_8000_0000);
    check("t1_pc1",   out_pc[1], 64'h0000_0000_8000_0004);
    check("t1_pc2",   out_pc[2], 64'h0000_0000_8000_0008);
    check("t1_ins0",  64'(out_ins[0]), 64'(ins_of(64'h0000_0000_8000_0000)));
    check("t1_ins2",  64'(out_ins[2]), 64'(ins_of(64'h0000_0000_8000_0008)));
    check("t1_rate",  64'(out_cyc[1] - out_cyc[0]), 64'd2);

    // Back-pressure fills the queue
    reset_dut();
    instr_ready_i = 1'b0;
    run(10);
    check("t2_nreq",   64'(req_log.size()), 64'd2);
    check("t2_req_lo", 64'(last_req),       64'h0);
    check("t2_valid",  64'(last_valid),     64'h1);
    check("t2_head",   instr_pc_o,          64'h0000_0000_8000_0000);
    check("t2_nout0",  64'(out_pc.size()),  64'd0);
    instr_ready_i = 1'b1;
    run(5);
    check("t2_nout",  64'(out_pc.size()), 64'd3);
    check("t2_pc0",   out_pc[0], 64'h0000_0000_8000_0000);
    check("t2_pc1",   out_pc[1], 64'h0000_0000_8000_0004);
    check("t2_pc2",   out_pc[2], 64'h0000_0000_8000_0008);
    check("t2_req2",  req_log[2], 64'h0000_0000_8000_0008);

    // Redirect while waiting for a slow response
    reset_dut();
    rv_extra = 1;
    run(1);
    redirect_i = 1'b1; redirect_pc_i = 64'h0000_0000_8000_0103;
    cyc();
    check("t3_req_redir", 64'(last_req), 64'h0);
    redirect_i = 1'b0;
    run(6);
    check("t3_req1", req_log[1], 64'h0000_0000_8000_0100);
    check("t3_nout", 64'(out_pc.size()), 64'd1);
    check("t3_pc0",  out_pc[0], 64'h0000_0000_8000_0100);
    check("t3_ins0", 64'(out_ins[0]), 64'(ins_of(64'h0000_0000_8000_0100)));

    // Redirect coincides with rvalid and a would-be pop
    reset_dut();
    instr_ready_i = 1'b0;
    run(3);
    instr_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 64'h0000_0000_8000_0200;
    cyc();
    check("t4_valid_mask", 64'(last_valid), 64'h0);
    redirect_i = 1'b0;
    cyc();
    check("t4_empty",  64'(last_valid), 64'h0);
    check("t4_req",    64'(last_req),   64'h1);
    check("t4_addr",   last_addr,       64'h0000_0000_8000_0200);
    run(2);
    check("t4_nout", 64'(out_pc.size()), 64'd1);
    check("t4_pc0",  out_pc[0], 64'h0000_0000_8000_0200);

    // Grant held off for three cycles
    reset_dut();
    gnt_wait = 3;
    run(5);
    check("t5_reqcyc",  64'(req_hi_cnt),     64'd4);
    check("t5_addrmov", 64'(addr_bad),       64'd0);
    check("t5_nreq",    64'(req_log.size()), 64'd1);
    check("t5_req0",    req_log[0],          64'h0000_0000_8000_0000);
    gnt_wait = 0;

    // Reset asserted mid-fetch, response arrives afterwards
    reset_dut();
    rv_extra = 1;
    run(1);
    rst_i = 1'b1;
    #1;
    check("t6_req",   64'(imem_req_o),    64'h0);
    check("t6_valid", 64'(instr_valid_o), 64'h0);
    check("t6_instr", 64'(instr_o),       64'h0);
    check("t6_ipc",   instr_pc_o,         64'h0);
    check("t6_addr",  imem_addr_o,        64'h0000_0000_8000_0000);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    pend_cnt = 0; pend_addr = 64'h0000_0000_0000_0040; rv_extra = 0;
    cyc();
    check("t6_req1",  64'(last_req), 64'h1);
    check("t6_addr1", last_addr,     64'h0000_0000_8000_0000);
    run(2);
    check("t6_nout", 64'(out_pc.size()), 64'd1);
    check("t6_pc0",  out_pc[0], 64'h0000_0000_8000_0000);
    check("t6_ins0", 64'(out_ins[0]), 64'(ins_of(64'h0000_0000_8000_0000)));

    // PC wrap at the top of the address space
    reset_dut();
    redirect_i = 1'b1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFE;
    cyc();
    check("t7_req_redir", 64'(last_req), 64'h0);
    redirect_i = 1'b0;
    run(4);
    check("t7_req0", req_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
    check("t7_req1", req_log[1], 64'h0);
    check("t7_pc0",  out_pc[0],  64'hFFFF_FFFF_FFFF_FFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
